mips_control_fsm: RTL and testbench
===================================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port Op, input, 6 bits: instruction bits [31:26].
REQ-004 SHALL have port Funct, input, 6 bits: instruction bits [5:0].
REQ-005 SHALL have port Zero, input, 1 bit: ALU result equals zero.
REQ-006 SHALL have outputs PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite and ALUSrcA, 1 bit each, plus PCSrc, 1 bit: datapath controls.
REQ-007 SHALL have output ALUSrcB, 2 bits: 0=B, 1=constant 4, 2=SignImm, 3=SignImm<<2.
REQ-008 SHALL have output ALUControl, 3 bits: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-009 SHALL have output State, 4 bits: current state encoding, for debug.
REQ-010 SHALL have output InstrDone, 1 bit: high during the final state of each instruction.
REQ-011 SHALL use these datapath select polarities: IorD 1=PC, 0=ALUOut; RegDst 1=rt, 0=rd; MemtoReg 1=ALUOut, 0=memory data; ALUSrcA 0=PC, 1=A; PCSrc 0=ALUResult, 1=ALUOut.

Function
REQ-012 SHALL implement a multicycle Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10.
REQ-013 SHALL drive each output to 0 in every state unless listed below, with ALUControl defaulting to 010.
REQ-014 SHALL in FETCH drive IorD=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=0 and PCEn=1, then go to DECODE.
REQ-015 SHALL in DECODE drive ALUSrcA=0 and ALUSrcB=11, then go to MEMADR for Op 100011/101011, EXECUTE for 000000, BRANCH for 000100, ADDIEXEC for 001000, and FETCH for any other Op.
REQ-016 SHALL in MEMADR drive ALUSrcA=1 and ALUSrcB=10, then go to MEMREAD if Op=100011, else MEMWRITE.
REQ-017 SHALL in MEMREAD drive IorD=0 and go to MEMWB; MEMWB drives RegDst=1, MemtoReg=0, RegWrite=1 and goes to FETCH.
REQ-018 SHALL in MEMWRITE drive IorD=0 and MemWrite=1, then go to FETCH.
REQ-019 SHALL in EXECUTE drive ALUSrcA=1, ALUSrcB=00 and ALUControl decoded from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other value add), then go to ALUWB.
REQ-020 SHALL in ALUWB drive RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-021 SHALL in BRANCH drive ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=1 and PCEn=Zero (the only Mealy output), then go to FETCH.
REQ-022 SHALL in ADDIEXEC drive ALUSrcA=1 and ALUSrcB=10, then go to ADDIWB; ADDIWB drives RegDst=1, MemtoReg=1, RegWrite=1 and goes to FETCH.
REQ-023 SHALL assert InstrDone in MEMWB, MEMWRITE, ALUWB, BRANCH and ADDIWB, and in DECODE when Op is illegal.
REQ-024 SHALL give cycle counts of lw 5, sw 4, R-type 4, beq 3, addi 4 and illegal 2.
REQ-025 SHALL treat Op and Funct as stable only during DECODE and the states after it; their values during FETCH are ignored.
REQ-026 SHALL return any unused State encoding (11-15) to FETCH on the next edge with all enables low.

Reset
REQ-027 SHALL, while rst=0, immediately force State=FETCH and PCEn=IRWrite=MemWrite=RegWrite=InstrDone=0, independent of clk.
REQ-028 SHALL perform FETCH with its full outputs on the first rising edge after rst deasserts, and SHALL abort any instruction in progress on reset with no further writes.

Configuration
REQ-029 SHALL, with ADDI_EN defined, include ADDIEXEC and ADDIWB and decode Op 001000 as addi.
REQ-030 SHALL, with ADDI_EN undefined, omit states 9-10 and treat Op 001000 as illegal (DECODE->FETCH, InstrDone=1).

Verification
REQ-031 SHALL cover lw (Op=100011): State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with RegDst=1 and MemtoReg=0.
REQ-032 SHALL cover R-type sub (Op=0, Funct=100010): ALUControl=110 in EXECUTE; ALUWB has RegWrite=1, RegDst=0, MemtoReg=1.
REQ-033 SHALL cover beq with Zero=1 then Zero=0: PCEn=1 with PCSrc=1 in BRANCH for the first, PCEn=0 for the second; 3 cycles each.
REQ-034 SHALL cover sw (Op=101011): MemWrite=1 for exactly one cycle in state 5 with IorD=0; RegWrite never asserted.
REQ-035 SHALL cover rst pulled low mid-MEMWB (state 4): RegWrite drops to 0 without a clk edge and State=0; after release, FETCH outputs appear.
REQ-036 SHALL cover Op=001000 run in both builds: ADDI_EN gives states 1,9,10 with ALUSrcB=10; without ADDI_EN, DECODE returns to FETCH with InstrDone=1.

Source files
------------

// File: rtl/mips_control_fsm.sv
// mips_control_fsm
//   Multicycle MIPS control unit (Moore FSM, with PCEn in BRANCH following Zero).
//   Optional build macro: ADDI_EN -- when defined, adds ADDIEXEC/ADDIWB and
//   decodes Op 001000 as addi; when undefined, that Op is treated as illegal.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst        : asynchronous reset, active low
//   Op, Funct  : instruction fields [31:26] and [5:0], valid from DECODE onward
//   Zero       : ALU result equals zero
//   PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc
//              : 1-bit datapath controls
//   ALUSrcB    : 0=B, 1=4, 2=SignImm, 3=SignImm<<2
//   ALUControl : 010 add, 110 sub, 000 and, 001 or, 111 slt
//   State      : current state encoding (debug)
//   InstrDone  : high in the final state of each instruction
//
// State | meaning
//   0  FETCH    | read instruction at PC, PC <= PC+4
//   1  DECODE   | read registers, precompute branch target
//   2  MEMADR   | compute lw/sw address
//   3  MEMREAD  | read data memory
//   4  MEMWB    | write loaded data to rt
//   5  MEMWRITE | write B to data memory
//   6  EXECUTE  | R-type ALU operation
//   7  ALUWB    | write ALU result to rd
//   8  BRANCH   | beq compare, conditional PC update
//   9  ADDIEXEC | addi ALU operation (ADDI_EN only)
//  10  ADDIWB   | write addi result to rt (ADDI_EN only)

module mips_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8
`ifdef ADDI_EN
    ,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       pc_en;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       instr_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    pc_en      = 1'b0;
    IorD       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    reg_write  = 1'b0;
    ALUSrcA    = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b010;
    instr_done = 1'b0;

    case (state_q)
      FETCH: begin
        IorD     = 1'b1;
        ir_write = 1'b1;
        ALUSrcB  = 2'b01;
        pc_en    = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXECUTE;
          6'b000100:            state_d = BRANCH;
`ifdef ADDI_EN
          6'b001000:            state_d = ADDIEXEC;
`endif
          default: begin
            // Unsupported opcode: retire immediately and fetch the next one.
            state_d    = FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == 6'b100011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        state_d = MEMWB;
      end
      MEMWB: begin
        RegDst     = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        MemtoReg   = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 1'b1;
        pc_en      = Zero;
        instr_done = 1'b1;
      end
`ifdef ADDI_EN
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegDst     = 1'b1;
        MemtoReg   = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: begin
        // Unused encodings: all controls stay at defaults, recover to FETCH.
        state_d = FETCH;
      end
    endcase
  end

  // Write enables are gated by reset so they drop immediately when rst falls,
  // even though the Moore decode of FETCH would otherwise raise PCEn/IRWrite.
  assign PCEn      = pc_en      & rst;
  assign MemWrite  = mem_write  & rst;
  assign IRWrite   = ir_write   & rst;
  assign RegWrite  = reg_write  & rst;
  assign InstrDone = instr_done & rst;
  assign State     = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
module tb_mips_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCSrc, InstrDone;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] State;

  mips_control_fsm dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .State(State), .InstrDone(InstrDone)
  );

  always #5 clk = ~clk;

`ifdef ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] state;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcsrc;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic       done;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t seq[6];
  int   seq_len;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    e.aluctl = 3'b010;
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference model: expected per-cycle outputs of one whole instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    exp_t e;
    bit   is_lw, is_sw, is_r, is_beq, is_addi;
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_r    = (op == 6'b000000);
    is_beq  = (op == 6'b000100);
    is_addi = ADDI_ON && (op == 6'b001000);

    e = blank(4'd0); e.iord = 1; e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1;
    seq[0] = e;
    e = blank(4'd1); e.alusrcb = 2'b11;
    e.done = !(is_lw || is_sw || is_r || is_beq || is_addi);
    seq[1] = e;
    seq_len = 2;
    if (is_lw || is_sw) begin
      e = blank(4'd2); e.alusrca = 1; e.alusrcb = 2'b10; seq[2] = e;
      if (is_lw) begin
        e = blank(4'd3); seq[3] = e;
        e = blank(4'd4); e.regdst = 1; e.regwrite = 1; e.done = 1; seq[4] = e;
        seq_len = 5;
      end else begin
        e = blank(4'd5); e.memwrite = 1; e.done = 1; seq[3] = e;
        seq_len = 4;
      end
    end else if (is_r) begin
      e = blank(4'd6); e.alusrca = 1; e.aluctl = alu_of(funct); seq[2] = e;
      e = blank(4'd7); e.memtoreg = 1; e.regwrite = 1; e.done = 1; seq[3] = e;
      seq_len = 4;
    end else if (is_beq) begin
      e = blank(4'd8); e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 1;
      e.pcen = zero; e.done = 1; seq[2] = e;
      seq_len = 3;
    end else if (is_addi) begin
      e = blank(4'd9); e.alusrca = 1; e.alusrcb = 2'b10; seq[2] = e;
      e = blank(4'd10); e.regdst = 1; e.memtoreg = 1; e.regwrite = 1; e.done = 1; seq[3] = e;
      seq_len = 4;
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after
  // the instruction has retired. Op/Funct are garbage during FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                           input int upto);
    build(op, funct, zero);
    for (int i = 0; i < seq_len && i < upto; i++) begin
      if (i == 0) begin
        Op = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom);
      end else begin
        Op = op; Funct = funct; Zero = zero;
      end
      exp_q.push_back(seq[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     32'(State),     32'd0);
    check({tag, "_pcen"},      32'(PCEn),      32'd0);
    check({tag, "_irwrite"},   32'(IRWrite),   32'd0);
    check({tag, "_memwrite"},  32'(MemWrite),  32'd0);
    check({tag, "_regwrite"},  32'(RegWrite),  32'd0);
    check({tag, "_instrdone"}, 32'(InstrDone), 32'd0);
  endtask

  // Monitor: every cycle out of reset presents one output vector.
  always @(negedge clk) begin
    exp_t act, e;
    if (rst && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = '{State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
              ALUSrcA, PCSrc, ALUSrcB, ALUControl, InstrDone};
      cyc++;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL cycle%0d state=%0d actual=%h expected=%h", cyc, e.state, act, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int kind;
    logic [5:0] f;
    logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b1;

    run_instr(6'b100011, 6'h00, 1'b0, 99);        // lw
    run_instr(6'b000000, 6'b100010, 1'b0, 99);    // sub
    run_instr(6'b000100, 6'h00, 1'b1, 99);        // beq taken
    run_instr(6'b000100, 6'h00, 1'b0, 99);        // beq not taken
    run_instr(6'b101011, 6'h00, 1'b1, 99);        // sw
    run_instr(6'b001000, 6'h00, 1'b0, 99);        // addi (build-dependent)
    run_instr(6'b111111, 6'h00, 1'b0, 99);        // illegal

    // Reset asserted while in MEMWB: RegWrite must drop without a clock edge.
    run_instr(6'b100011, 6'h00, 1'b0, 4);
    #1;
    check("memwb_state_before", 32'(State), 32'd4);
    check("memwb_regwrite_before", 32'(RegWrite), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst = 1'b1;
    run_instr(6'b000000, 6'b101010, 1'b0, 99);    // slt after reset

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 6);
      f = functs[$urandom_range(0, 4)];
      case (kind)
        0: run_instr(6'b100011, 6'($urandom), 1'($urandom), 99);
        1: run_instr(6'b101011, 6'($urandom), 1'($urandom), 99);
        2: run_instr(6'b000000, f, 1'($urandom), 99);
        3: run_instr(6'b000100, 6'($urandom), 1'($urandom), 99);
        4: run_instr(6'b001000, 6'($urandom), 1'($urandom), 99);
        5: run_instr(6'($urandom), 6'($urandom), 1'($urandom), 99);
        default: run_instr(6'b000000, 6'($urandom), 1'($urandom), 99);
      endcase
    end

    @(negedge clk); #1;
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
